vslc_scan_sequencer: RTL and testbench

Generalised scan-cycle controller for the VSLC PLC core. It sits between the EEPROM byte reader and the executor. It parses the program header (start/end address), gates instruction bytes to the executor, and detects end-of-program. It restarts the reader under a selectable trigger mode (auto, external, periodic, single-shot) and latches an N-channel input image plus previous image at each scan start. It also flags header errors and scan overruns.

---
 rtl/vslc_pkg.sv | 36 +++
 rtl/vslc_scan_sequencer_if.sv | 33 +++
 rtl/vslc_sync_edge.sv | 42 ++++
 rtl/vslc_scan_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_vslc_scan_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vslc_pkg.sv
// ---------------------------------------------------------------------------
// vslc_pkg
// Shared definitions for the VSLC scan sequencer:
//   - trigger mode encodings (value of the 2-bit mode input)
//   - scan FSM state enum
//   - byte offsets of the fixed 4-byte program header
//   - header sanity helper
// ---------------------------------------------------------------------------
package vslc_pkg;

  localparam logic [1:0] MODE_AUTO     = 2'd0;
  localparam logic [1:0] MODE_EXT      = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;
  localparam logic [1:0] MODE_SINGLE   = 2'd3;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } scan_state_e;

  // Header layout: start_hi, start_lo, end_hi, end_lo at addresses 0..3.
  localparam logic [15:0] HDR_START_HI = 16'd0;
  localparam logic [15:0] HDR_START_LO = 16'd1;
  localparam logic [15:0] HDR_END_HI   = 16'd2;
  localparam logic [15:0] HDR_END_LO   = 16'd3;

  // A header is bad when a non-empty program ends before it starts.
  // end == 0 means "empty program" and is never an error.
  function automatic logic hdr_is_bad(input logic [15:0] start_a,
                                      input logic [15:0] end_a);
    return (end_a != 16'd0) && (end_a < start_a);
  endfunction

endpackage

// File: rtl/vslc_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// vslc_scan_sequencer_if
// Byte path between the EEPROM reader, the scan sequencer and the executor.
//   rd_valid    reader -> seq   one-cycle strobe, byte present on rd_addr/rd_data
//   rd_addr     reader -> seq   16-bit address of the byte
//   rd_data     reader -> seq   byte value
//   restart     seq -> reader   one-cycle pulse, reader reloads start_addr
//   instr_valid seq -> executor rd_valid qualified as a program byte
//
// Handshake: strobe semantics, there is no ready/back-pressure. A byte is
// transferred in exactly the cycle rd_valid is high; instr_valid is asserted
// in that same cycle (combinationally) so the executor samples rd_data
// alongside it. restart is a registered single-cycle pulse.
//
// Modports: master = reader/executor side, slave = sequencer.
// ---------------------------------------------------------------------------
interface vslc_scan_sequencer_if;
  logic        rd_valid;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        restart;
  logic        instr_valid;

  modport master (
    output rd_valid, rd_addr, rd_data,
    input  restart, instr_valid
  );

  modport slave (
    input  rd_valid, rd_addr, rd_data,
    output restart, instr_valid
  );
endinterface

// File: rtl/vslc_sync_edge.sv
// ---------------------------------------------------------------------------
// vslc_sync_edge
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector. rise is high for one cycle, two clk edges after the input rises,
// so a consumer registering on rise acts on the third edge.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   async_in  in   asynchronous input pin
//   rise      out  one-cycle pulse on a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module vslc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/vslc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// vslc_scan_sequencer
// Scan-cycle controller between the EEPROM byte reader and the executor.
// Parses the program header, gates program bytes to the executor, detects
// end-of-program and restarts the reader according to the trigger mode.
// Latches an input image (and the previous one) at every scan start.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mode           trigger mode (MODE_*), evaluated in WAIT
//   period         PERIODIC scan period in clk cycles (0 = behave as AUTO)
//   ext_trig       asynchronous external trigger, rising-edge sensitive
//   in_pins        raw input pins
//   bus            reader/executor byte path (slave modport)
//   start_addr     parsed program start
//   end_addr       parsed program end (0 = empty program, runs forever)
//   hdr_err        sticky header error (cleared only by reset)
//   overrun        sticky PERIODIC overrun
//   scan_pulse     one-cycle pulse at each scan start
//   in_img/in_prev input image of the current / previous scan
//   state_o        FSM state, for observation
// ---------------------------------------------------------------------------
module vslc_scan_sequencer
  import vslc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int N_IN      = 8,
  parameter int PERIOD_W  = 16,
  parameter int HDR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [PERIOD_W-1:0]   period,
  input  logic                  ext_trig,
  input  logic [N_IN-1:0]       in_pins,
  vslc_scan_sequencer_if.slave  bus,
  output logic [ADDR_W-1:0]     start_addr,
  output logic [ADDR_W-1:0]     end_addr,
  output logic                  hdr_err,
  output logic                  overrun,
  output logic                  scan_pulse,
  output logic [N_IN-1:0]       in_img,
  output logic [N_IN-1:0]       in_prev,
  output scan_state_e           state_o
);

  localparam int HI_W = ADDR_W - 8;
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  scan_state_e         state_q,    state_d;
  logic [HI_W-1:0]     start_hi_q, start_hi_d;
  logic [7:0]          start_lo_q, start_lo_d;
  logic [HI_W-1:0]     end_hi_q,   end_hi_d;
  logic [7:0]          end_lo_q,   end_lo_d;
  logic                armed_q,    armed_d;
  logic                hdr_err_q,  hdr_err_d;
  logic                overrun_q,  overrun_d;
  logic                restart_q,  restart_d;
  logic                scan_pulse_q, scan_pulse_d;
  logic [N_IN-1:0]     in_img_q,   in_img_d;
  logic [N_IN-1:0]     in_prev_q,  in_prev_d;
  logic [PERIOD_W-1:0] cnt_q,      cnt_d;

  // -------------------------------------------------------------------------
  // External trigger synchroniser
  // -------------------------------------------------------------------------
  logic ext_rise;

  vslc_sync_edge u_trig_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ext_trig),
    .rise     (ext_rise)
  );

  // -------------------------------------------------------------------------
  // Byte qualification
  // -------------------------------------------------------------------------
  logic [15:0] start16;
  logic [15:0] end16;
  logic        armed_eff;
  logic        instr_ok;
  logic        end_of_scan;
  logic        period_hit;
  logic        do_scan;
  logic        do_restart;

  assign start16 = 16'({start_hi_q, start_lo_q});
  assign end16   = 16'({end_hi_q, end_lo_q});

  // The byte at start_addr arms the gate and is itself forwarded, so the
  // arming condition is folded in combinationally.
  assign armed_eff = armed_q || (bus.rd_valid && (bus.rd_addr == start16));

  assign instr_ok = (state_q == ST_RUN) && bus.rd_valid &&
                    (bus.rd_addr >= 16'(HDR_BYTES)) && armed_eff;

  // The end byte is still forwarded (instr_ok holds for it).
  assign end_of_scan = instr_ok && (end16 != 16'd0) && (bus.rd_addr >= end16);

  // Counter saturates, so ">=" also covers a count that ran past period-1.
  assign period_hit = (period != '0) && (cnt_q >= (period - CNT_ONE));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    start_hi_d   = start_hi_q;
    start_lo_d   = start_lo_q;
    end_hi_d     = end_hi_q;
    end_lo_d     = end_lo_q;
    armed_d      = armed_q;
    hdr_err_d    = hdr_err_q;
    overrun_d    = overrun_q;
    in_img_d     = in_img_q;
    in_prev_d    = in_prev_q;
    restart_d    = 1'b0;
    scan_pulse_d = 1'b0;
    do_scan      = 1'b0;
    do_restart   = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (bus.rd_valid) begin
          case (bus.rd_addr)
            HDR_START_HI: start_hi_d = bus.rd_data[HI_W-1:0];
            HDR_START_LO: start_lo_d = bus.rd_data;
            HDR_END_HI:   end_hi_d   = bus.rd_data[HI_W-1:0];
            HDR_END_LO: begin
              end_lo_d = bus.rd_data;
              // End address is judged with the byte arriving now.
              if (hdr_is_bad(start16, 16'({end_hi_q, bus.rd_data}))) begin
                hdr_err_d = 1'b1;
                state_d   = ST_HALT;
              end else begin
                // First scan: the reader is already streaming on from the
                // header, so no restart pulse here.
                do_scan = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (instr_ok) begin
          armed_d = 1'b1;
        end
        if (end_of_scan) begin
          // A PERIODIC scan that already used up its period restarts on the
          // end-of-scan edge itself instead of passing through WAIT.
          if ((mode == MODE_PERIODIC) && period_hit) begin
            overrun_d  = 1'b1;
            do_scan    = 1'b1;
            do_restart = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        case (mode)
          MODE_AUTO: begin
            do_scan    = 1'b1;
            do_restart = 1'b1;
          end
          MODE_EXT: begin
            if (ext_rise) begin
              do_scan    = 1'b1;
              do_restart = 1'b1;
            end
          end
          MODE_PERIODIC: begin
            if ((period == '0) || period_hit) begin
              do_scan    = 1'b1;
              do_restart = 1'b1;
            end
          end
          default: state_d = ST_HALT;   // MODE_SINGLE
        endcase
      end

      ST_HALT: begin
        if (ext_rise && !hdr_err_q) begin
          do_scan    = 1'b1;
          do_restart = 1'b1;
        end
      end

      default: state_d = ST_HDR;
    endcase

    // Scan-start action shared by header completion and every restart.
    if (do_scan) begin
      scan_pulse_d = 1'b1;
      restart_d    = do_restart;
      in_img_d     = in_pins;
      in_prev_d    = in_img_q;
      armed_d      = 1'b0;
      state_d      = ST_RUN;
    end

    if (do_scan) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HDR;
      start_hi_q   <= '0;
      start_lo_q   <= '0;
      end_hi_q     <= '0;
      end_lo_q     <= '0;
      armed_q      <= 1'b0;
      hdr_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      restart_q    <= 1'b0;
      scan_pulse_q <= 1'b0;
      in_img_q     <= '0;
      in_prev_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_hi_q   <= start_hi_d;
      start_lo_q   <= start_lo_d;
      end_hi_q     <= end_hi_d;
      end_lo_q     <= end_lo_d;
      armed_q      <= armed_d;
      hdr_err_q    <= hdr_err_d;
      overrun_q    <= overrun_d;
      restart_q    <= restart_d;
      scan_pulse_q <= scan_pulse_d;
      in_img_q     <= in_img_d;
      in_prev_q    <= in_prev_d;
      cnt_q        <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.restart     = restart_q;
  assign bus.instr_valid = instr_ok;
  assign start_addr      = {start_hi_q, start_lo_q};
  assign end_addr        = {end_hi_q, end_lo_q};
  assign hdr_err         = hdr_err_q;
  assign overrun         = overrun_q;
  assign scan_pulse      = scan_pulse_q;
  assign in_img          = in_img_q;
  assign in_prev         = in_prev_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vslc_scan_sequencer
// Directed bench for vslc_scan_sequencer: header parsing, AUTO / EXTERNAL /
// PERIODIC / SINGLE triggering, overrun, header error, empty program and
// asynchronous reset. Forwarded program bytes are checked by a monitor
// against an expected queue filled by the byte driver.
// ---------------------------------------------------------------------------
module tb_vslc_scan_sequencer;
  import vslc_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int N_IN     = 8;
  localparam int PERIOD_W = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          mode     = MODE_AUTO;
  logic [PERIOD_W-1:0] period   = '0;
  logic                ext_trig = 1'b0;
  logic [N_IN-1:0]     in_pins  = '0;
  logic [ADDR_W-1:0]   start_addr, end_addr;
  logic                hdr_err, overrun, scan_pulse;
  logic [N_IN-1:0]     in_img, in_prev;
  scan_state_e         state_o;

  vslc_scan_sequencer_if bus ();

  vslc_scan_sequencer #(
    .ADDR_W(ADDR_W), .N_IN(N_IN), .PERIOD_W(PERIOD_W), .HDR_BYTES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .period(period),
    .ext_trig(ext_trig), .in_pins(in_pins), .bus(bus),
    .start_addr(start_addr), .end_addr(end_addr), .hdr_err(hdr_err),
    .overrun(overrun), .scan_pulse(scan_pulse), .in_img(in_img),
    .in_prev(in_prev), .state_o(state_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int restart_cnt = 0;
  int scan_cnt = 0;
  int last_restart_cyc = 0;
  int last_scan_cyc = 0;
  logic [23:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.restart) begin
      restart_cnt      <= restart_cnt + 1;
      last_restart_cyc <= cyc;
    end
    if (scan_pulse) begin
      scan_cnt      <= scan_cnt + 1;
      last_scan_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [23:0] got;
    logic [23:0] want;
    if (bus.instr_valid) begin
      got = {bus.rd_addr, bus.rd_data};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL instr_unexpected actual=%0h expected=none (t=%0t)", got, $time);
      end else begin
        want = exp_q.pop_front();
        check("instr_byte", got, want);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dat(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit expect_v);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    bus.rd_data  = d;
    if (expect_v) exp_q.push_back({a, d});
    tick();
    bus.rd_valid = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] sh, input logic [7:0] sl,
                             input logic [7:0] eh, input logic [7:0] el);
    send_byte(16'd0, sh, 1'b0);
    send_byte(16'd1, sl, 1'b0);
    send_byte(16'd2, eh, 1'b0);
    send_byte(16'd3, el, 1'b0);
  endtask

  // Program bytes 5..8, all forwarded; gap idle cycles between bytes.
  task automatic send_prog(input int gap);
    for (int a = 5; a <= 8; a++) begin
      send_byte(16'(a), dat(16'(a)), 1'b1);
      if (a != 8) repeat (gap) tick();
    end
  endtask

  task automatic wait_scan(input int budget, input string name);
    int base;
    base = scan_cnt;
    for (int i = 0; i < budget && scan_cnt == base; i++) tick();
    if (scan_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_scan_pulse expected=scan_pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_start"},   32'(start_addr), 32'd0);
    check({name, "_end"},     32'(end_addr),   32'd0);
    check({name, "_flags"},   {28'd0, hdr_err, overrun, scan_pulse, bus.restart}, 32'd0);
    check({name, "_img"},     {16'd0, in_img, in_prev}, 32'd0);
    check({name, "_ivalid"},  32'(bus.instr_valid), 32'd0);
    check({name, "_state"},   32'(state_o), 32'(ST_HDR));
  endtask

  // ---------------- stimulus ----------------
  int k, t0, p0, p1, s0, r0;

  initial begin
    bus.rd_valid = 1'b0;
    bus.rd_addr  = '0;
    bus.rd_data  = '0;

    // Reset state
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // AUTO: header 00,05,00,08
    mode    = MODE_AUTO;
    in_pins = 8'h11;
    send_header(8'h00, 8'h05, 8'h00, 8'h08);
    check("hdr_start", 32'(start_addr), 32'd5);
    check("hdr_end", 32'(end_addr), 32'd8);
    check("hdr_scan_pulse", 32'(scan_pulse), 32'd1);
    check("hdr_no_restart", 32'(bus.restart), 32'd0);
    check("hdr_state_run", 32'(state_o), 32'(ST_RUN));
    check("hdr_img", {16'd0, in_img, in_prev}, 32'h1100);
    tick();
    check("hdr_pulse_once", 32'(scan_pulse), 32'd0);
    send_byte(16'd4, dat(16'd4), 1'b0);
    send_prog(0);
    k = cyc;
    check("auto_wait", 32'(state_o), 32'(ST_WAIT));
    tick();
    check("auto_restart", 32'(bus.restart), 32'd1);
    check("auto_restart_lat", 32'(last_restart_cyc >= 0 ? cyc - k : 0), 32'd1);
    check("auto_scan_pulse", 32'(scan_pulse), 32'd1);
    mode = MODE_EXT;
    tick();
    check("auto_restart_once", {30'd0, bus.restart, scan_pulse}, 32'd0);

    // EXTERNAL: trigger during RUN is ignored
    r0 = restart_cnt;
    ext_trig = 1'b1;
    repeat (6) tick();
    ext_trig = 1'b0;
    repeat (3) tick();
    check("ext_in_run_state", 32'(state_o), 32'(ST_RUN));
    check("ext_in_run_no_restart", 32'(restart_cnt), 32'(r0));
    send_prog(0);
    repeat (3) tick();
    check("ext_wait_hold", 32'(state_o), 32'(ST_WAIT));
    in_pins  = 8'hA5;
    t0       = cyc;
    ext_trig = 1'b1;
    wait_scan(10, "ext_trig1");
    ext_trig = 1'b0;
    check("ext_lat1", 32'(last_restart_cyc - t0), 32'd3);
    check("ext_img1", 32'(in_img), 32'hA5);
    send_prog(0);
    repeat (3) tick();
    in_pins  = 8'h3C;
    t0       = cyc;
    ext_trig = 1'b1;
    wait_scan(10, "ext_trig2");
    ext_trig = 1'b0;
    check("ext_lat2", 32'(last_restart_cyc - t0), 32'd3);
    check("ext_img2", {16'd0, in_img, in_prev}, 32'h3CA5);
    p0 = last_scan_cyc;

    // PERIODIC period=50, scans of about 20 cycles
    mode   = MODE_PERIODIC;
    period = 16'd50;
    send_prog(5);
    wait_scan(100, "periodic1");
    p1 = last_scan_cyc;
    check("periodic_spacing1", 32'(p1 - p0), 32'd50);
    send_prog(5);
    wait_scan(100, "periodic2");
    check("periodic_spacing2", 32'(last_scan_cyc - p1), 32'd50);
    check("periodic_no_overrun", 32'(overrun), 32'd0);

    // PERIODIC period=10: overrun, restart on the end-of-scan edge
    period = 16'd10;
    send_prog(5);
    check("overrun_flag", 32'(overrun), 32'd1);
    check("overrun_restart", 32'(bus.restart), 32'd1);
    check("overrun_state", 32'(state_o), 32'(ST_RUN));
    tick();
    check("overrun_restart_once", 32'(bus.restart), 32'd0);

    // SINGLE: one scan then HALT; ext_trig gives exactly one more
    mode   = MODE_SINGLE;
    period = '0;
    send_prog(0);
    repeat (3) tick();
    check("single_halt", 32'(state_o), 32'(ST_HALT));
    s0       = scan_cnt;
    ext_trig = 1'b1;
    wait_scan(10, "single_trig");
    ext_trig = 1'b0;
    check("single_run", 32'(state_o), 32'(ST_RUN));
    send_prog(0);
    repeat (8) tick();
    check("single_halt2", 32'(state_o), 32'(ST_HALT));
    check("single_one_scan", 32'(scan_cnt), 32'(s0 + 1));
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset asserted mid-RUN, off the clock edge
    ext_trig = 1'b1;
    wait_scan(10, "pre_reset_trig");
    ext_trig = 1'b0;
    send_byte(16'd5, dat(16'd5), 1'b1);
    send_byte(16'd6, dat(16'd6), 1'b1);
    check("pre_reset_run", 32'(state_o), 32'(ST_RUN));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("drain_a", 32'(exp_q.size()), 32'd0);

    // Bad header 00,08,00,05
    send_header(8'h00, 8'h08, 8'h00, 8'h05);
    check("bad_hdr_err", 32'(hdr_err), 32'd1);
    check("bad_hdr_state", 32'(state_o), 32'(ST_HALT));
    check("bad_hdr_no_pulse", {30'd0, bus.restart, scan_pulse}, 32'd0);
    s0       = scan_cnt;
    ext_trig = 1'b1;
    repeat (6) tick();
    ext_trig = 1'b0;
    check("bad_hdr_stay_halt", 32'(state_o), 32'(ST_HALT));
    check("bad_hdr_no_scan", 32'(scan_cnt), 32'(s0));
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("bad_hdr_cleared", 32'(hdr_err), 32'd0);

    // Empty program (end=0), high bytes masked to ADDR_W-8 bits
    mode    = MODE_AUTO;
    in_pins = 8'h77;
    r0      = restart_cnt;
    send_header(8'hFC, 8'h05, 8'hFC, 8'h00);
    check("empty_start", 32'(start_addr), 32'd5);
    check("empty_end", 32'(end_addr), 32'd0);
    check("empty_img", {16'd0, in_img, in_prev}, 32'h7700);
    send_byte(16'd4, dat(16'd4), 1'b0);
    for (int a = 5; a <= 13; a++) send_byte(16'(a), dat(16'(a)), 1'b1);
    repeat (5) tick();
    check("empty_run", 32'(state_o), 32'(ST_RUN));
    check("empty_no_restart", 32'(restart_cnt), 32'(r0));

    tick();
    check("drain_final", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
